// File: rtl/frame_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_stream_sequencer_if
//  Purpose  : Host word stream, weight-load and pixel-stream signals of the
//             frame stream sequencer, bundled with sequencer/environment views.
//  Revision : 1.0  initial release
// ============================================================================
interface frame_stream_sequencer_if #(
   parameter int WORD_W = 12,
   parameter int PIX_W  = 4
);
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic              w_valid;
   logic [WORD_W-1:0] w_data;
   logic              p_valid;
   logic [PIX_W-1:0]  p_data;
   logic              p_ready;

   // master: the sequencer itself; slave: the host/CNN environment around it
   modport master (
      input  s_valid, s_data, p_ready,
      output s_ready, w_valid, w_data, p_valid, p_data
   );
   modport slave (
      output s_valid, s_data, p_ready,
      input  s_ready, w_valid, w_data, p_valid, p_data
   );
endinterface
`default_nettype wire

// File: rtl/frame_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_stream_sequencer
//  Purpose  : Routes one host word stream first to the DNN weight-load port,
//             then as FIFO-buffered pixel frames to the CNN pixel port.
//             Optional macro FRAME_CHECKSUM_EN adds the per-frame XOR output
//             frame_csum.
//  Revision : 1.0  initial release
// ============================================================================
module frame_stream_sequencer #(
   parameter int BIT_SIZE       = 4,
   parameter int M_W_BIT_SIZE   = 4,
   parameter int MAX_NUM_NERVES = 3,
   parameter int IMAGE_WIDTH    = 8,
   parameter int CHANNELS       = 1,
   parameter int WEIGHT_ROWS    = 7,
   parameter int FIFO_DEPTH     = 4,
   parameter int NUM_FRAMES     = 0
) (
   input  wire                             clk,
   input  wire                             res,
   frame_stream_sequencer_if.master        bus,
   input  wire                             reload,
   output logic [1:0]                      phase,
   output logic                            frame_done,
   output logic [15:0]                     frame_count
`ifdef FRAME_CHECKSUM_EN
   ,
   output logic [CHANNELS*BIT_SIZE-1:0]    frame_csum
`endif
);

   localparam int C_WORD_W    = MAX_NUM_NERVES * M_W_BIT_SIZE;
   localparam int C_PIX_W     = CHANNELS * BIT_SIZE;
   localparam int C_PIX_TOTAL = IMAGE_WIDTH * IMAGE_WIDTH;
   localparam int C_PIX_CW    = (C_PIX_TOTAL > 1) ? $clog2(C_PIX_TOTAL) : 1;
   localparam int C_LOAD_CW   = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1;
   localparam int C_AW        = $clog2(FIFO_DEPTH);

   localparam logic [C_PIX_CW-1:0]  C_PIX_LAST    = C_PIX_CW'(C_PIX_TOTAL - 1);
   localparam logic [C_LOAD_CW-1:0] C_LOAD_LAST   = C_LOAD_CW'(WEIGHT_ROWS - 1);
   localparam logic [15:0]          C_FRAME_LIMIT = 16'(NUM_FRAMES);

   typedef enum logic [1:0] {
      ST_LOAD_W = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [C_LOAD_CW-1:0]  load_cnt_q, load_cnt_d;
   logic [C_PIX_CW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [15:0]           frame_count_q, frame_count_d;
   logic                  reload_pend_q, reload_pend_d;
   logic                  w_valid_q, w_valid_d;
   logic [C_WORD_W-1:0]   w_data_q, w_data_d;
   logic [C_AW:0]         wr_ptr_q, wr_ptr_d;
   logic [C_AW:0]         rd_ptr_q, rd_ptr_d;
   logic [C_PIX_W-1:0]    mem_q [FIFO_DEPTH];
   logic [C_PIX_W-1:0]    mem_d [FIFO_DEPTH];

   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  s_ready_raw;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [C_PIX_W-1:0]    pix_in;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[C_AW] != rd_ptr_q[C_AW]) &&
                   (wr_ptr_q[C_AW-1:0] == rd_ptr_q[C_AW-1:0]);

      s_ready_raw = 1'b0;
      case (state_q)
         ST_LOAD_W: s_ready_raw = 1'b1;
         ST_STREAM: s_ready_raw = !fifo_full;
         default:   s_ready_raw = 1'b0;
      endcase

      // Held low while reset is asserted so the host never sees a handshake
      bus.s_ready = s_ready_raw && !res;
      accept      = bus.s_valid && bus.s_ready;
      push        = accept && (state_q == ST_STREAM);
      pop         = !fifo_empty && bus.p_ready;
      pix_in      = bus.s_data[C_PIX_W-1:0];
      frame_done  = (state_q == ST_DRAIN) && fifo_empty;
   end

   always_comb begin
      state_d       = state_q;
      load_cnt_d    = load_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      frame_count_d = frame_count_q;
      reload_pend_d = reload_pend_q | (reload && (state_q != ST_LOAD_W));
      w_valid_d     = 1'b0;
      w_data_d      = w_data_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      mem_d         = mem_q;

      if (push) begin
         mem_d[wr_ptr_q[C_AW-1:0]] = pix_in;
         wr_ptr_d                  = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case (state_q)
         ST_LOAD_W: begin
            if (accept) begin
               w_valid_d = 1'b1;
               w_data_d  = bus.s_data;
               if (load_cnt_q == C_LOAD_LAST) begin
                  load_cnt_d    = '0;
                  frame_count_d = '0;
                  state_d       = ST_STREAM;
               end else begin
                  load_cnt_d = load_cnt_q + C_LOAD_CW'(1);
               end
            end
         end
         ST_STREAM: begin
            if (push) begin
               if (pix_cnt_q == C_PIX_LAST) begin
                  pix_cnt_d = '0;
                  state_d   = ST_DRAIN;
               end else begin
                  pix_cnt_d = pix_cnt_q + C_PIX_CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               frame_count_d = frame_count_q + 16'd1;
               if (reload_pend_q) begin
                  state_d = ST_LOAD_W;
               end else if ((C_FRAME_LIMIT != 16'd0) &&
                            (frame_count_q + 16'd1 == C_FRAME_LIMIT)) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         default: begin
            if (reload || reload_pend_q) begin
               state_d = ST_LOAD_W;
            end
         end
      endcase

      // A reload request is consumed by the transition into the load phase
      if ((state_d == ST_LOAD_W) && (state_q != ST_LOAD_W)) begin
         reload_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q       <= ST_LOAD_W;
         load_cnt_q    <= '0;
         pix_cnt_q     <= '0;
         frame_count_q <= '0;
         reload_pend_q <= 1'b0;
         w_valid_q     <= 1'b0;
         w_data_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         load_cnt_q    <= load_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         frame_count_q <= frame_count_d;
         reload_pend_q <= reload_pend_d;
         w_valid_q     <= w_valid_d;
         w_data_q      <= w_data_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         mem_q         <= mem_d;
      end
   end

   always_comb begin
      bus.w_valid = w_valid_q;
      bus.w_data  = w_data_q;
      bus.p_valid = !fifo_empty;
      bus.p_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[C_AW-1:0]];
      phase       = state_q;
      frame_count = frame_count_q;
   end

`ifdef FRAME_CHECKSUM_EN
   logic [C_PIX_W-1:0] csum_acc_q, csum_acc_d;
   logic [C_PIX_W-1:0] frame_csum_q, frame_csum_d;

   always_comb begin
      csum_acc_d   = csum_acc_q;
      frame_csum_d = frame_csum_q;
      if (push) begin
         csum_acc_d = (pix_cnt_q == '0) ? pix_in : (csum_acc_q ^ pix_in);
      end
      if (frame_done) begin
         frame_csum_d = csum_acc_q;
      end
      // The accumulator is frozen during DRAIN, so it is already final here
      frame_csum = frame_done ? csum_acc_q : frame_csum_q;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         csum_acc_q   <= '0;
         frame_csum_q <= '0;
      end else begin
         csum_acc_q   <= csum_acc_d;
         frame_csum_q <= frame_csum_d;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_stream_sequencer
//  Purpose  : Directed stimulus against a queue-based behavioural model of
//             the frame stream sequencer, checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_stream_sequencer;
   localparam int BS = 4, MW = 4, MN = 3, IW = 8, CH = 1, WR = 7, FD = 4, NF = 2;
   localparam int WW = MN * MW, PW = CH * BS, NPIX = IW * IW;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        reload = 1'b0;
   logic [1:0]  phase;
   logic        frame_done;
   logic [15:0] frame_count;
`ifdef FRAME_CHECKSUM_EN
   logic [PW-1:0] frame_csum;
`endif

   frame_stream_sequencer_if #(.WORD_W(WW), .PIX_W(PW)) bus ();

   frame_stream_sequencer #(
      .BIT_SIZE(BS), .M_W_BIT_SIZE(MW), .MAX_NUM_NERVES(MN), .IMAGE_WIDTH(IW),
      .CHANNELS(CH), .WEIGHT_ROWS(WR), .FIFO_DEPTH(FD), .NUM_FRAMES(NF)
   ) dut (
      .clk(clk), .res(res), .bus(bus), .reload(reload),
      .phase(phase), .frame_done(frame_done), .frame_count(frame_count)
`ifdef FRAME_CHECKSUM_EN
      , .frame_csum(frame_csum)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int w_pulses = 0, beats = 0, fd_cnt = 0;
   logic [PW-1:0] csum_at_fd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: event not seen, expected within budget at %0t", name, $time);
   endtask

   // ---------------- behavioural model (phase codes as published) ----------
   int            m_phase = 0, m_loaded = 0, m_pix = 0, nxt;
   logic [PW-1:0] m_fifo[$];
   logic [15:0]   m_fc = '0;
   bit            m_pend = 0, m_ok = 0, m_wv = 0, e_sr, e_fd, acc, pop;
   logic [WW-1:0] m_wd = '0;
   logic [PW-1:0] m_cur = '0, m_last = '0, d;

   always @(negedge clk) begin
      e_sr = !res && (m_phase == 0 || (m_phase == 1 && m_fifo.size() < FD));
      e_fd = (m_phase == 2) && (m_fifo.size() == 0);
      if (m_ok) begin
         chk("s_ready", bus.s_ready, e_sr);
         chk("w_valid", bus.w_valid, m_wv);
         if (m_wv) chk("w_data", bus.w_data, m_wd);
         chk("p_valid", bus.p_valid, m_fifo.size() != 0);
         if (m_fifo.size() != 0) chk("p_data", bus.p_data, m_fifo[0]);
         chk("phase", phase, m_phase);
         chk("frame_done", frame_done, e_fd);
         chk("frame_count", frame_count, m_fc);
`ifdef FRAME_CHECKSUM_EN
         chk("frame_csum", frame_csum, e_fd ? m_cur : m_last);
`endif
      end
      if (bus.w_valid) w_pulses++;
      if (bus.p_valid && bus.p_ready) beats++;
      if (frame_done) begin
         fd_cnt++;
`ifdef FRAME_CHECKSUM_EN
         csum_at_fd = frame_csum;
`endif
      end
      // advance the model across the coming rising edge
      if (res) begin
         m_phase = 0; m_loaded = 0; m_pix = 0; m_fifo.delete(); m_fc = '0;
         m_pend = 0; m_wv = 0; m_wd = '0; m_cur = '0; m_last = '0; m_ok = 1;
      end else if (m_ok) begin
         acc  = bus.s_valid && e_sr;
         pop  = (m_fifo.size() != 0) && bus.p_ready;
         m_wv = 0;
         nxt  = m_phase;
         if (pop) void'(m_fifo.pop_front());
         case (m_phase)
            0: if (acc) begin
                  m_wv = 1; m_wd = bus.s_data; m_loaded++;
                  if (m_loaded == WR) begin m_loaded = 0; m_fc = '0; nxt = 1; end
               end
            1: if (acc) begin
                  d = bus.s_data[PW-1:0];
                  m_fifo.push_back(d);
                  m_cur = (m_pix == 0) ? d : (m_cur ^ d);
                  m_pix++;
                  if (m_pix == NPIX) begin m_pix = 0; nxt = 2; end
               end
            2: if (e_fd) begin
                  m_last = m_cur; m_fc++;
                  if (m_pend) nxt = 0;
                  else if (NF != 0 && m_fc == NF) nxt = 3;
                  else nxt = 1;
               end
            default: if (reload || m_pend) nxt = 0;
         endcase
         if (nxt == 0 && m_phase != 0) m_pend = 0;
         else if (reload && m_phase != 0) m_pend = 1;
         m_phase = nxt;
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic try_send(input logic [WW-1:0] w, input int budget, output bit ok);
      int n = 0;
      ok = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      while (n < budget) begin
         @(negedge clk);
         if (bus.s_ready) begin ok = 1; break; end
         n++;
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic send(input logic [WW-1:0] w);
      bit ok;
      try_send(w, 400, ok);
      if (!ok) timeout_fail("send");
   endtask

   task automatic wait_fd(input int budget);
      int s = fd_cnt, n = 0;
      while (fd_cnt == s) begin
         @(posedge clk);
         n++;
         if (n > budget) begin timeout_fail("frame_done"); break; end
      end
      #1;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
   endtask

   function automatic logic [WW-1:0] pat(input int k);
      return WW'((k * 5 + 3) % 16);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w0, b0, f0, accn;
      bit  ok;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.p_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("rst s_ready", bus.s_ready, 0);
      chk("rst w_valid", bus.w_valid, 0);
      chk("rst p_valid", bus.p_valid, 0);
      chk("rst phase", phase, 0);
      chk("rst frame_count", frame_count, 0);
      res = 1'b0;

      // weight load
      for (int i = 0; i < WR; i++) send(WW'(12'h123 + i));
      repeat (2) @(posedge clk); #1;
      chk("t1 w pulses", w_pulses, 7);
      chk("t1 last w_data", bus.w_data, 12'h129);
      chk("t1 phase", phase, 1);

      // frame 1, free-running sink
      b0 = beats; f0 = fd_cnt;
      for (int i = 0; i < NPIX; i++) send((i % 2) ? 12'h2 : 12'h7);
      wait_fd(200);
      chk("t2 beats", beats - b0, 64);
      chk("t2 frame_done pulses", fd_cnt - f0, 1);
      chk("t2 frame_count", frame_count, 1);
      chk("t2 phase", phase, 1);

      // frame 2 with a stalled sink
      bus.p_ready = 1'b0; accn = 0; b0 = beats;
      for (int k = 0; k < 5; k++) begin
         try_send(pat(k), 12, ok);
         if (ok) accn++;
      end
      chk("t3 accepted while stalled", accn, 4);
      chk("t3 s_ready stalled", bus.s_ready, 0);
      chk("t3 phase stalled", phase, 1);
      bus.p_ready = 1'b1;
      for (int k = 4; k < NPIX; k++) send(pat(k));
      wait_fd(200);
      chk("t3 beats", beats - b0, 64);
      chk("t4 phase hold", phase, 3);
      chk("t4 s_ready hold", bus.s_ready, 0);
      chk("t4 frame_count", frame_count, 2);

      // reload from HOLD
      pulse_reload();
      chk("t4 phase reload", phase, 0);
      w0 = w_pulses;
      for (int i = 0; i < WR; i++) send(WW'(12'h3A0 + i));
      repeat (2) @(posedge clk); #1;
      chk("t4 w pulses", w_pulses - w0, 7);
      chk("t4 last w_data", bus.w_data, 12'h3A6);
      chk("t4 frame_count cleared", frame_count, 0);

      // reload mid-frame, then reset mid-frame
      for (int k = 0; k < 30; k++) send(pat(k + 1));
      pulse_reload();
      for (int k = 30; k < NPIX; k++) send(pat(k + 1));
      wait_fd(200);
      chk("t5 phase after reload", phase, 0);
      chk("t5 frame_count", frame_count, 1);
      for (int i = 0; i < WR; i++) send(WW'(12'h050 + i));
      for (int k = 0; k < 6; k++) send(pat(k + 7));
      repeat (3) @(posedge clk); #1;
      bus.p_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(pat(k + 9));
      chk("t5 p_valid before reset", bus.p_valid, 1);
      res = 1'b1;
      @(posedge clk); #1;
      chk("t5 rst p_valid", bus.p_valid, 0);
      chk("t5 rst p_data", bus.p_data, 0);
      chk("t5 rst phase", phase, 0);
      chk("t5 rst s_ready", bus.s_ready, 0);
      chk("t5 rst w_valid", bus.w_valid, 0);
      chk("t5 rst frame_count", frame_count, 0);
      @(posedge clk); #1;
      res = 1'b0; bus.p_ready = 1'b1;
      @(posedge clk); #1;
      chk("t5 post-rst s_ready", bus.s_ready, 1);
      chk("t5 post-rst p_valid", bus.p_valid, 0);

      // checksum frame
      for (int i = 0; i < WR; i++) send(WW'(12'h100 + i));
      for (int k = 0; k < NPIX - 1; k++) send(12'h0);
      send(12'hF);
      wait_fd(200);
      chk("t6 frame_count", frame_count, 1);
`ifdef FRAME_CHECKSUM_EN
      chk("t6 frame_csum", csum_at_fd, 4'hF);
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/frame_stream_sequencer.md
Name: frame_stream_sequencer

Overview:
- Front-end sequencer for the CNN+DNN top.
- Accepts one host word stream and routes it in two phases:
  - first, WeightRows rows of DNN weights onto the weight-load port;
  - then repeated frames of Channels-wide pixels onto the CNN pixel port.
- Pixels pass through a FIFO so downstream backpressure (out_ready) never drops data.
- Generalises single-channel, single-frame, fixed-size stimulus sequencing to parametrised channels, frame counts and weight reload.

Parameters:
- BitSize, 4, pixel bits per channel.
- M_W_BitSize, 4, weight bits.
- MaxNumNerves, 3, weights per weight row.
- ImageWidth, 8, frame is ImageWidth*ImageWidth pixels.
- Channels, 1, pixel channels per beat. Must satisfy Channels*BitSize <= MaxNumNerves*M_W_BitSize.
- WeightRows, 7, weight rows loaded per load phase (sum of layer input counts).
- FifoDepth, 4, pixel FIFO entries, power of two, >= 2.
- NumFrames, 0, frames per weight load; 0 = unlimited.

Ports:
- clk, in, 1, clock, rising edge.
- res, in, 1, synchronous active-high reset.
- s_valid, in, 1, host word valid.
- s_ready, out, 1, host word accepted when s_valid && s_ready.
- s_data, in, MaxNumNerves*M_W_BitSize, host word; pixel phase uses bits [Channels*BitSize-1:0].
- reload, in, 1, pulse: reload weights after the current frame.
- w_valid, out, 1, weight row valid (one cycle per row).
- w_data, out, MaxNumNerves*M_W_BitSize, weight row.
- p_valid, out, 1, pixel beat valid.
- p_data, out, Channels*BitSize, pixel beat.
- p_ready, in, 1, downstream ready (CNN out_ready).
- phase, out, 2, 0=LOAD_W, 1=STREAM, 2=DRAIN, 3=HOLD.
- frame_done, out, 1, one-cycle pulse at end of frame.
- frame_count, out, 16, frames completed since last weight load; wraps at 2^16.

Behaviour:
- Reset values (all outputs):
  - s_ready=0, w_valid=0, w_data=0, p_valid=0, p_data=0.
  - phase=LOAD_W, frame_done=0, frame_count=0.
  - FIFO emptied, all counters=0, pending-reload flag=0.
- Reset mid-operation discards all in-flight pixels and weight progress; the next cycle restarts at LOAD_W.
- LOAD_W:
  - s_ready=1.
  - Each accepted word appears on w_data with w_valid=1 exactly one cycle later (registered).
  - w_valid=0 in all other cycles and all other phases.
  - After WeightRows accepts: go to STREAM and clear frame_count.
- STREAM:
  - s_ready = !fifo_full.
  - An accepted word pushes s_data[Channels*BitSize-1:0] into the FIFO.
  - Pixel counter increments per push. At ImageWidth^2 pushes it clears and the FSM goes to DRAIN.
  - In the frame's final cycle s_ready stays asserted only for that last push; the next cycle s_ready=0.
- DRAIN:
  - s_ready=0.
  - When FIFO empty (last pop complete): frame_done=1 for one cycle and frame_count increments.
  - Next state, in priority order:
    - pending reload → LOAD_W;
    - NumFrames!=0 and frame_count+1==NumFrames → HOLD;
    - else → STREAM.
- HOLD:
  - s_ready=0; idle until reload, then go to LOAD_W.
- FIFO:
  - p_valid = !fifo_empty; p_data = head entry.
  - Pop when p_valid && p_ready.
  - Push-to-p_valid latency is 1 cycle.
  - Push and pop in the same cycle are both permitted, including when full (pop frees the slot; s_ready already reflects full before the edge, so no push on full).
  - The FIFO is drained in every phase. STREAM overlaps with popping of the prior frame only through the FIFO; the frame boundary is serialised by DRAIN.
- reload:
  - Captured into the pending flag in any phase except LOAD_W (ignored there).
  - Honoured at the next DRAIN exit, or immediately when in HOLD.
- p_ready held low indefinitely: FIFO fills, s_ready=0, no data lost, no state change.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- When defined:
  - Adds output frame_csum, width Channels*BitSize: XOR of all pixel words pushed in the frame.
  - Valid and stable from the frame_done cycle until the next frame_done.
  - Accumulator clears on the frame's first push and on reset; frame_csum resets to 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset, then 7 weight words 0x123..0x129 with s_valid=1 → w_valid pulses on 7 consecutive cycles, one cycle after each accept, same values; phase becomes 1 after the 7th.
2. 64 pixels alternating 4'h7/4'h2, p_ready=1 → 64 p_valid beats in order; frame_done pulses once; frame_count=1; phase returns to 1.
3. p_ready=0 during pixel stream, FifoDepth=4 → exactly 4 pixels accepted then s_ready=0. Raising p_ready yields the 4 pixels in order, then streaming resumes with no loss or duplicates.
4. NumFrames=2, two frames streamed → phase=3 after the second frame_done; s_ready=0. A reload pulse → phase=0; the next 7 words appear on w_data.
5. reload pulsed mid-frame, then res asserted 10 pixels into the next frame → after the first: frame finishes, phase=0. After reset: all outputs zero, FIFO empty, phase=0.
6. FRAME_CHECKSUM_EN, frame of 63×4'h0 plus one 4'hF → frame_csum=4'hF at frame_done.
